// File: rtl/superscalar_ctrl_decode_if.sv
// Bundle-in / decoded-bundle-out handshake bus for superscalar_ctrl_decode.
// The master side feeds opcodes and takes results; the slave side is the decoder.
interface superscalar_ctrl_decode_if #(
  parameter int LANES = 2,
  parameter int OPC_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       in_lane_vld;
  logic [LANES*OPC_W-1:0] in_opcode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_lane_vld;
  logic [LANES*16-1:0]    out_ctrl;
  logic [LANES-1:0]       out_illegal;

  modport master (
    output in_valid, in_lane_vld, in_opcode, out_ready,
    input  in_ready, out_valid, out_lane_vld, out_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_lane_vld, in_opcode, out_ready,
    output in_ready, out_valid, out_lane_vld, out_ctrl, out_illegal
  );
endinterface

// File: rtl/superscalar_ctrl_decode.sv
// Multi-lane opcode decoder with registered output and one-entry skid buffer.
// Latency 1 cycle; in_ready drops only when the skid entry is occupied.
module superscalar_ctrl_decode #(
  parameter int LANES           = 2,
  parameter int OPC_W           = 4,
  parameter int SQUASH_AFTER_BR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  superscalar_ctrl_decode_if.slave bus
);

  typedef struct packed {
    logic [LANES-1:0]    lane_vld;
    logic [LANES*16-1:0] ctrl;
    logic [LANES-1:0]    illegal;
  } bundle_t;

  function automatic logic [15:0] decode_ctrl(input logic [3:0] op);
    logic [15:0] c;
    case (op)
      4'h1:    c = 16'h4001;
      4'h2:    c = 16'h4002;
      4'h3:    c = 16'h4004;
      4'h4:    c = 16'h4008;
      4'h5:    c = 16'h0010;
      4'h6:    c = 16'h0020;
      4'h7:    c = 16'h4040;
      4'h8:    c = 16'h4080;
      4'h9:    c = 16'h4100;
      4'hA:    c = 16'h4200;
      4'hB:    c = 16'h4400;
      4'hC:    c = 16'h8000;
      4'hD:    c = 16'h4800;
      4'hE:    c = 16'h1000;
      4'hF:    c = 16'h2000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hE) || (op == 4'hF);
  endfunction

  logic [OPC_W-1:0] w_op [LANES];
  bundle_t          w_dec;
  logic             w_br_seen;
  logic             w_accept;
  logic             w_fire;

  bundle_t r_or;
  bundle_t r_sk;
  logic    r_or_vld;
  logic    r_sk_vld;

  for (genvar g = 0; g < LANES; g++) begin : g_op
    assign w_op[g] = bus.in_opcode[g*OPC_W +: OPC_W];
  end

  // Walk lanes oldest-first; once a legal branch is seen, younger lanes stay zero.
  always_comb begin
    w_dec     = '0;
    w_br_seen = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_lane_vld[i]) begin
        if ((w_op[i] >> 4) != '0) begin
          w_dec.illegal[i] = 1'b1;
        end else if (!w_br_seen) begin
          w_dec.lane_vld[i]        = 1'b1;
          w_dec.ctrl[i*16 +: 16]   = decode_ctrl(w_op[i][3:0]);
          if ((SQUASH_AFTER_BR != 0) && is_branch(w_op[i][3:0])) begin
            w_br_seen = 1'b1;
          end
        end
      end
    end
  end

  assign w_accept = bus.in_valid && !r_sk_vld;
  assign w_fire   = r_or_vld && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_or_vld <= 1'b0;
      r_sk_vld <= 1'b0;
      r_or     <= '0;
      r_sk     <= '0;
    end else if (flush) begin
      r_or_vld <= 1'b0;
      r_sk_vld <= 1'b0;
    end else if (w_fire) begin
      // With SK occupied in_ready is low, so no accept can race the refill.
      if (r_sk_vld) begin
        r_or     <= r_sk;
        r_or_vld <= 1'b1;
        r_sk_vld <= 1'b0;
      end else if (w_accept) begin
        r_or     <= w_dec;
        r_or_vld <= 1'b1;
      end else begin
        r_or_vld <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_or_vld) begin
        r_or     <= w_dec;
        r_or_vld <= 1'b1;
      end else begin
        r_sk     <= w_dec;
        r_sk_vld <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = !r_sk_vld;
  assign bus.out_valid    = r_or_vld;
  assign bus.out_lane_vld = r_or.lane_vld;
  assign bus.out_ctrl     = r_or.ctrl;
  assign bus.out_illegal  = r_or.illegal;

endmodule

// File: tb/tb_superscalar_ctrl_decode.sv
// Directed bench for superscalar_ctrl_decode: three configurations (squash on,
// squash off, 5-bit opcodes) sharing clock, reset and flush.
module tb_superscalar_ctrl_decode;
  logic clk;
  logic reset;
  logic flush;
  int   n_chk;
  int   n_pass;

  superscalar_ctrl_decode_if #(.LANES(2), .OPC_W(4)) sif0 ();
  superscalar_ctrl_decode_if #(.LANES(2), .OPC_W(4)) sif1 ();
  superscalar_ctrl_decode_if #(.LANES(2), .OPC_W(5)) sif2 ();

  superscalar_ctrl_decode #(.LANES(2), .OPC_W(4), .SQUASH_AFTER_BR(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(sif0));
  superscalar_ctrl_decode #(.LANES(2), .OPC_W(4), .SQUASH_AFTER_BR(0)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(sif1));
  superscalar_ctrl_decode #(.LANES(2), .OPC_W(5), .SQUASH_AFTER_BR(1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .bus(sif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    sif0.in_valid = 1'b0; sif0.in_lane_vld = '0; sif0.in_opcode = '0; sif0.out_ready = 1'b1;
    sif1.in_valid = 1'b0; sif1.in_lane_vld = '0; sif1.in_opcode = '0; sif1.out_ready = 1'b1;
    sif2.in_valid = 1'b0; sif2.in_lane_vld = '0; sif2.in_opcode = '0; sif2.out_ready = 1'b1;
    flush = 1'b0;
  endtask

  task automatic send0(input logic [7:0] opc, input logic [1:0] lv);
    sif0.in_valid = 1'b1; sif0.in_opcode = opc; sif0.in_lane_vld = lv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", sif0.in_ready); else n_pass++;
    n_chk++; if (sif0.out_ctrl !== 32'h0) $display("FAIL reset_ctrl got %h exp 0", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b00) $display("FAIL reset_lane_vld got %b exp 00", sif0.out_lane_vld); else n_pass++;
    n_chk++; if (sif0.out_illegal !== 2'b00) $display("FAIL reset_illegal got %b exp 00", sif0.out_illegal); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    send0(8'h41, 2'b11);
    tick();
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.out_ctrl !== 32'h4008_4001) $display("FAIL basic_ctrl got %h exp 40084001", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b11) $display("FAIL basic_lane_vld got %b exp 11", sif0.out_lane_vld); else n_pass++;
    tick();
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL basic_drain got %b exp 0", sif0.out_valid); else n_pass++;
  endtask

  task automatic test_squash();
    send0(8'h1E, 2'b11);
    sif1.in_valid = 1'b1; sif1.in_opcode = 8'h1E; sif1.in_lane_vld = 2'b11;
    tick();
    sif0.in_valid = 1'b0; sif1.in_valid = 1'b0;
    n_chk++; if (sif0.out_ctrl !== 32'h0000_1000) $display("FAIL squash_ctrl got %h exp 00001000", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b01) $display("FAIL squash_lane_vld got %b exp 01", sif0.out_lane_vld); else n_pass++;
    n_chk++; if (sif1.out_ctrl !== 32'h4001_1000) $display("FAIL nosquash_ctrl got %h exp 40011000", sif1.out_ctrl); else n_pass++;
    n_chk++; if (sif1.out_lane_vld !== 2'b11) $display("FAIL nosquash_lane_vld got %b exp 11", sif1.out_lane_vld); else n_pass++;
    // Lane 0 invalid: its beq must not squash lane 1.
    send0(8'h1E, 2'b10);
    tick();
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_ctrl !== 32'h4001_0000) $display("FAIL invbr_ctrl got %h exp 40010000", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b10) $display("FAIL invbr_lane_vld got %b exp 10", sif0.out_lane_vld); else n_pass++;
    send0(8'h00, 2'b00);
    tick();
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_valid !== 1'b1) $display("FAIL empty_valid got %b exp 1", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b00) $display("FAIL empty_lane_vld got %b exp 00", sif0.out_lane_vld); else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    sif2.in_valid = 1'b1; sif2.in_opcode = {5'h05, 5'h11}; sif2.in_lane_vld = 2'b11;
    tick();
    n_chk++; if (sif2.out_illegal !== 2'b01) $display("FAIL ill_flag got %b exp 01", sif2.out_illegal); else n_pass++;
    n_chk++; if (sif2.out_ctrl !== 32'h0010_0000) $display("FAIL ill_ctrl got %h exp 00100000", sif2.out_ctrl); else n_pass++;
    n_chk++; if (sif2.out_lane_vld !== 2'b10) $display("FAIL ill_lane_vld got %b exp 10", sif2.out_lane_vld); else n_pass++;
    // Illegal beq pattern in lane 0 must not squash the add in lane 1.
    sif2.in_opcode = {5'h01, 5'h1E};
    tick();
    sif2.in_valid = 1'b0;
    n_chk++; if (sif2.out_ctrl !== 32'h4001_0000) $display("FAIL illbr_ctrl got %h exp 40010000", sif2.out_ctrl); else n_pass++;
    n_chk++; if (sif2.out_lane_vld !== 2'b10) $display("FAIL illbr_lane_vld got %b exp 10", sif2.out_lane_vld); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    sif0.out_ready = 1'b0;
    send0(8'h41, 2'b11);
    tick();
    send0(8'h78, 2'b11);
    tick();
    n_chk++; if (sif0.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", sif0.in_ready); else n_pass++;
    send0(8'h65, 2'b11);
    tick();
    n_chk++; if (sif0.out_ctrl !== 32'h4008_4001) $display("FAIL bp_hold_A got %h exp 40084001", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.in_ready !== 1'b0) $display("FAIL bp_hold_ready got %b exp 0", sif0.in_ready); else n_pass++;
    sif0.out_ready = 1'b1;
    tick();
    n_chk++; if (sif0.out_ctrl !== 32'h4040_4080 || sif0.out_valid !== 1'b1) $display("FAIL bp_B got %h/%b exp 40404080/1", sif0.out_ctrl, sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", sif0.in_ready); else n_pass++;
    tick();
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_ctrl !== 32'h0020_0010 || sif0.out_valid !== 1'b1) $display("FAIL bp_C got %h/%b exp 00200010/1", sif0.out_ctrl, sif0.out_valid); else n_pass++;
    tick();
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", sif0.out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    sif0.out_ready = 1'b0;
    send0(8'h41, 2'b11);
    tick();
    send0(8'h78, 2'b11);
    tick();
    send0(8'h65, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", sif0.in_ready); else n_pass++;
    sif0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL flush_stale%0d got %b exp 0", i, sif0.out_valid); else n_pass++;
    end
    // Flush while in_ready is high: the presented bundle is dropped too.
    sif0.out_ready = 1'b0;
    send0(8'h41, 2'b11);
    tick();
    send0(8'h78, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sif0.in_valid = 1'b0;
    sif0.out_ready = 1'b1;
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL flush2_valid got %b exp 0", sif0.out_valid); else n_pass++;
    tick();
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL flush2_stale got %b exp 0", sif0.out_valid); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    sif0.out_ready = 1'b0;
    send0(8'h41, 2'b11);
    tick();
    sif0.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL mrst_valid got %b exp 0", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.out_ctrl !== 32'h0) $display("FAIL mrst_ctrl got %h exp 0", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.in_ready !== 1'b1) $display("FAIL mrst_ready got %b exp 1", sif0.in_ready); else n_pass++;
    sif0.out_ready = 1'b1;
    send0(8'hFC, 2'b11);
    tick();
    sif0.in_valid = 1'b0;
    n_chk++; if (sif0.out_valid !== 1'b1) $display("FAIL mrst_first_valid got %b exp 1", sif0.out_valid); else n_pass++;
    n_chk++; if (sif0.out_ctrl !== 32'h0000_8000) $display("FAIL mrst_first_ctrl got %h exp 00008000", sif0.out_ctrl); else n_pass++;
    n_chk++; if (sif0.out_lane_vld !== 2'b01) $display("FAIL mrst_first_lane_vld got %b exp 01", sif0.out_lane_vld); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  opc [4];
    logic [31:0] exp_ctrl [4];
    opc[0] = 8'hB2; exp_ctrl[0] = 32'h4400_4002;
    opc[1] = 8'hD3; exp_ctrl[1] = 32'h4800_4004;
    opc[2] = 8'h09; exp_ctrl[2] = 32'h0000_4100;
    opc[3] = 8'hFA; exp_ctrl[3] = 32'h2000_4200;
    sif0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send0(opc[i], 2'b11);
      tick();
      n_chk++; if (sif0.out_valid !== 1'b1 || sif0.out_ctrl !== exp_ctrl[i]) $display("FAIL b2b_%0d got %h/%b exp %h/1", i, sif0.out_ctrl, sif0.out_valid, exp_ctrl[i]); else n_pass++;
      n_chk++; if (sif0.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b exp 1", i, sif0.in_ready); else n_pass++;
    end
    sif0.in_valid = 1'b0;
    tick();
    n_chk++; if (sif0.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", sif0.out_valid); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_squash();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/superscalar_ctrl_decode.md
Name: superscalar_ctrl_decode

Overview:
Multi-lane successor of the single-issue decode control unit. It decodes LANES opcodes per bundle into packed per-lane control vectors. Results are registered behind a valid/ready handshake with a one-entry skid buffer, plus flush, illegal-opcode detection and optional squash of lanes younger than a taken-class branch. The block sits between fetch/issue and the register-read stage of the superscalar pipeline.

Parameters:
LANES, 2, instructions per bundle (1..8); lane 0 is oldest
OPC_W, 4, opcode width (>=4); bits [3:0] select the operation, nonzero upper bits mark the opcode illegal
SQUASH_AFTER_BR, 1, 1 = lanes younger than the first branch lane in a bundle are invalidated

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held and incoming bundles
in_valid  in  1  bundle valid
in_ready  out  1  block can accept a bundle
in_lane_vld  in  LANES  per-lane valid within the bundle
in_opcode  in  LANES*OPC_W  lane i at [i*OPC_W +: OPC_W]
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_lane_vld  out  LANES  per-lane valid after squash/illegal masking
out_ctrl  out  LANES*16  lane i at [i*16 +: 16]
out_illegal  out  LANES  lane held an illegal opcode

Behaviour:
- Ctrl bit order: 0 add, 1 sub, 2 mul, 3 ld, 4 st, 5 cmp, 6 mov, 7 or, 8 and, 9 not, 10 lsl, 11 lsr, 12 beq, 13 bgt, 14 wb, 15 ubranch.
- Opcode map [3:0]: 0 nop (all zero, legal), 1 add, 2 sub, 3 mul, 4 ld, 5 st, 6 cmp, 7 mov, 8 or, 9 and, A not, B lsl, C ubranch, D lsr, E beq, F bgt.
- wb=1 for add, sub, mul, ld, mov, or, and, not, lsl, lsr; wb=0 for all others.
- Illegal lane: ctrl=0, out_illegal=1, out_lane_vld=0. Lanes with in_lane_vld=0: ctrl=0, illegal=0, lane_vld=0.
- Squash (SQUASH_AFTER_BR=1): find the lowest valid legal lane k with beq, bgt or ubranch. Lanes j>k get lane_vld=0 and ctrl=0; lane k is kept. Illegal lanes do not trigger squash.
- Storage: output register (OR) plus skid register (SK), each holding a valid bit and a decoded bundle.
- in_ready = !SK.valid. It is registered and depends only on state.
- Accept occurs when in_valid && in_ready. Out-fire occurs when out_valid && out_ready.
- Latency: a bundle accepted in cycle N appears on out_* in cycle N+1 when OR is empty or firing.
- On accept, when OR is empty or firing in the same cycle: OR <- decoded input; otherwise SK <- decoded input.
- On out-fire with SK valid: OR <- SK and SK empties, in the same edge.
- Ordering is strict FIFO; no bundle is dropped or duplicated. Sustained throughput is 1 bundle/cycle while out_ready=1.
- out_* are driven from OR only and stay stable while out_valid && !out_ready.
- flush (synchronous): OR.valid=0 and SK.valid=0 on the next edge; a bundle presented in the flush cycle is discarded. flush takes priority over accept and fire.
- Reset: out_valid=0, in_ready=1 in the cycle after the reset edge, out_lane_vld=0, out_ctrl=0, out_illegal=0, SK empty. Reset mid-stream discards held bundles.
- in_valid with all lanes invalid is still accepted and emitted with out_lane_vld=0.

Test Plan:
- LANES=2, bundle {lane0=1 add, lane1=4 ld}, out_ready=1 -> next cycle out_valid=1, lane0 ctrl=0x4001, lane1 ctrl=0x4008, out_lane_vld=2'b11.
- Bundle {lane0=E beq, lane1=1 add}, squash on -> lane0 ctrl=0x1000, out_lane_vld=2'b01, lane1 ctrl=0; with SQUASH_AFTER_BR=0 -> out_lane_vld=2'b11.
- OPC_W=5, lane0=5'h11 -> out_illegal[0]=1, ctrl 0, lane_vld 0; lane1=5'h05 st -> ctrl=0x0010.
- Back-pressure: out_ready=0 while sending bundles A,B,C -> A in OR, B in SK, in_ready=0 and C held; raise out_ready -> A, B, C emitted in consecutive cycles, in order.
- flush asserted with OR and SK full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale bundle emitted afterwards.
- reset asserted mid-stream for 1 cycle -> after the edge out_valid=0, ctrl=0, in_ready=1; first post-reset bundle is emitted 1 cycle after accept.
